// File: rtl/mr_control_unit.sv
// Multicycle control FSM for the Maquina Rudimentaria datapath.
// Optional single-step mode is enabled with the MR_CU_STEP_EN macro.
module mr_control_unit #(
    parameter int ACK_TIMEOUT = 0,
    parameter int TW          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef MR_CU_STEP_EN
    input  logic       step,
`endif
    input  logic [1:0] ir_op,
    input  logic [2:0] ir_cond,
    input  logic [1:0] ir_fn,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_ack,
    output logic       ld_ir,
    output logic       ld_rdir,
    output logic       ld_pc,
    output logic       ld_regb,
    output logic       ld_ra,
    output logic       ld_flags,
    output logic       reset_pc_sel,
    output logic       pc_src,
    output logic       mux_1_pc,
    output logic       regb_src,
    output logic [1:0] regb_rsel,
    output logic       operar,
    output logic [1:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    output logic       halted,
    output logic       err,
`ifdef MR_CU_STEP_EN
    output logic [3:0] state
`else
    output logic [2:0] state
`endif
);

`ifdef MR_CU_STEP_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    localparam logic [SW-1:0] S_RST    = SW'(0);
    localparam logic [SW-1:0] S_FETCH  = SW'(1);
    localparam logic [SW-1:0] S_DECODE = SW'(2);
    localparam logic [SW-1:0] S_ALU    = SW'(3);
    localparam logic [SW-1:0] S_MEM_RD = SW'(4);
    localparam logic [SW-1:0] S_MEM_WR = SW'(5);
    localparam logic [SW-1:0] S_BRANCH = SW'(6);
    localparam logic [SW-1:0] S_HALT   = SW'(7);
`ifdef MR_CU_STEP_EN
    localparam logic [SW-1:0] S_WAIT_STEP = SW'(8);
    localparam logic [SW-1:0] S_AFTER     = S_WAIT_STEP;
`else
    localparam logic [SW-1:0] S_AFTER     = S_FETCH;
`endif

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next;
    logic [TW-1:0] r_wait_cnt;
    logic          r_err;
    logic          w_mem_req;
    logic          w_acked;
    logic          w_timeout;
    logic          w_taken;

    assign w_mem_req = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_acked   = w_mem_req && mem_ack;

    // Timeout fires on the ACK_TIMEOUT-th consecutive unacknowledged request cycle.
    always_comb begin
        w_timeout = 1'b0;
        if (ACK_TIMEOUT > 0)
            w_timeout = w_mem_req && !mem_ack && (r_wait_cnt == TW'(ACK_TIMEOUT - 1));
    end

    always_comb begin
        case (ir_cond)
            3'b000:  w_taken = 1'b1;
            3'b001:  w_taken = flag_z;
            3'b010:  w_taken = flag_n;
            3'b011:  w_taken = flag_z | flag_n;
            3'b100:  w_taken = !flag_z;
            3'b101:  w_taken = !flag_n;
            3'b110:  w_taken = !flag_z && !flag_n;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_AFTER;
            S_FETCH: begin
                if (w_timeout)    w_next = S_HALT;
                else if (mem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (ir_op)
                    2'b00: w_next = S_MEM_RD;
                    2'b01: w_next = S_MEM_WR;
                    2'b10: w_next = (ir_cond == 3'b111) ? S_HALT : S_BRANCH;
                    2'b11: w_next = S_ALU;
                endcase
            end
            S_ALU:    w_next = S_AFTER;
            S_MEM_RD, S_MEM_WR: begin
                if (w_timeout)    w_next = S_HALT;
                else if (mem_ack) w_next = S_AFTER;
            end
            S_BRANCH: w_next = S_AFTER;
            S_HALT:   w_next = S_HALT;
`ifdef MR_CU_STEP_EN
            S_WAIT_STEP: if (step) w_next = S_FETCH;
`endif
            default:  w_next = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RST;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (ACK_TIMEOUT > 0 && w_mem_req && !mem_ack && !w_timeout)
                r_wait_cnt <= r_wait_cnt + TW'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        ld_ir        = 1'b0;
        ld_rdir      = 1'b0;
        ld_pc        = 1'b0;
        ld_regb      = 1'b0;
        ld_ra        = 1'b0;
        ld_flags     = 1'b0;
        reset_pc_sel = 1'b0;
        pc_src       = 1'b0;
        mux_1_pc     = 1'b0;
        regb_src     = 1'b0;
        regb_rsel    = 2'd0;
        operar       = 1'b0;
        alu_op       = 2'b00;
        mem_we       = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_RST: begin
                ld_pc        = 1'b1;
                reset_pc_sel = 1'b1;
            end
            S_FETCH: begin
                ld_ir = w_acked;
                ld_pc = w_acked;
            end
            S_DECODE: begin
                ld_ra     = 1'b1;
                ld_rdir   = 1'b1;
                regb_rsel = (ir_op == 2'b11) ? 2'd0 : 2'd1;
            end
            S_ALU: begin
                operar   = 1'b1;
                alu_op   = ir_fn;
                ld_regb  = 1'b1;
                ld_flags = 1'b1;
            end
            S_MEM_RD: begin
                mux_1_pc = 1'b1;
                ld_regb  = w_acked;
                regb_src = w_acked;
                ld_flags = w_acked;
            end
            S_MEM_WR: begin
                mux_1_pc  = 1'b1;
                mem_we    = 1'b1;
                regb_rsel = 2'd2;
            end
            S_BRANCH: begin
                ld_pc  = w_taken;
                pc_src = w_taken;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_req = w_mem_req;
    assign err     = r_err;
    assign state   = r_state;

endmodule

// File: tb/tb_mr_control_unit.sv
// Testbench for mr_control_unit: table vectors, randomized instructions against a
// transaction-level sequence model, and directed halt/timeout/reset sequences.
module tb_mr_control_unit;

    localparam int ACK_TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] irOp = '0;
    logic [2:0] irCond = '0;
    logic [1:0] irFn = '0;
    logic       flagZ = 1'b0;
    logic       flagN = 1'b0;
    logic       memAck = 1'b0;

    logic ld_ir, ld_rdir, ld_pc, ld_regb, ld_ra, ld_flags;
    logic reset_pc_sel, pc_src, mux_1_pc, regb_src, operar;
    logic mem_req, mem_we, halted, err;
    logic [1:0] regb_rsel, alu_op;
`ifdef MR_CU_STEP_EN
    logic [3:0] stateFull;
`else
    logic [2:0] stateFull;
`endif

    mr_control_unit #(.ACK_TIMEOUT(ACK_TO), .TW(8)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MR_CU_STEP_EN
        .step(1'b1),
`endif
        .ir_op(irOp), .ir_cond(irCond), .ir_fn(irFn),
        .flag_z(flagZ), .flag_n(flagN), .mem_ack(memAck),
        .ld_ir(ld_ir), .ld_rdir(ld_rdir), .ld_pc(ld_pc), .ld_regb(ld_regb),
        .ld_ra(ld_ra), .ld_flags(ld_flags), .reset_pc_sel(reset_pc_sel),
        .pc_src(pc_src), .mux_1_pc(mux_1_pc), .regb_src(regb_src),
        .regb_rsel(regb_rsel), .operar(operar), .alu_op(alu_op),
        .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .err(err),
        .state(stateFull)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ldIr, ldRdir, ldPc, ldRegb, ldRa, ldFlags;
        logic       resetPcSel, pcSrc, mux1Pc, regbSrc;
        logic [1:0] regbRsel;
        logic       operar;
        logic [1:0] aluOp;
        logic       memReq, memWe, halted, err;
        logic [2:0] state;
    } outv_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] cond;
        logic [1:0] fn;
        logic       z, n;
        int         fd, ed;
        logic [2:0] expExec;
        logic       expTaken;
    } vec_t;

    outv_t actV;
    assign actV = {ld_ir, ld_rdir, ld_pc, ld_regb, ld_ra, ld_flags,
                   reset_pc_sel, pc_src, mux_1_pc, regb_src, regb_rsel,
                   operar, alu_op, mem_req, mem_we, halted, err, stateFull[2:0]};

    int   total = 0;
    int   bad = 0;
    logic mErr = 1'b0;

    function automatic outv_t base(input logic [2:0] st);
        outv_t e;
        e = '0;
        e.state = st;
        e.err = mErr;
        return e;
    endfunction

    function automatic outv_t rstOut();
        outv_t e;
        e = base(3'd0);
        e.ldPc = 1'b1;
        e.resetPcSel = 1'b1;
        return e;
    endfunction

    function automatic logic branchTaken(input logic [2:0] c, input logic z, input logic n);
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return n;
            3'd3: return z || n;
            3'd4: return !z;
            3'd5: return !n;
            3'd6: return !z && !n;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] execOf(input logic [1:0] op);
        logic [2:0] tbl [4];
        tbl = '{3'd4, 3'd5, 3'd6, 3'd3};
        return tbl[op];
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] cond, input logic [1:0] fn,
                                 input logic z, input logic n);
        irOp = op;
        irCond = cond;
        irFn = fn;
        flagZ = z;
        flagN = n;
    endtask

    // Drives mem_ack for one cycle, compares at the falling edge, then steps past the next rising edge.
    task automatic checkOutput(input string tag, input outv_t exp, input logic ack);
        memAck = ack;
        @(negedge clk);
        total++;
        if (actV !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%b want=%b (state got %0d want %0d)",
                     tag, actV, exp, actV.state, exp.state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        mErr = 1'b0;
        checkOutput({tag, "_asserted"}, rstOut(), 1'b1);
        rst_n = 1'b1;
        checkOutput({tag, "_released"}, rstOut(), 1'($urandom_range(0, 1)));
    endtask

    task automatic runFetch(input string tag, input int fd);
        outv_t e;
        for (int k = 0; k <= fd; k++) begin
            e = base(3'd1);
            e.memReq = 1'b1;
            if (k == fd) begin
                e.ldIr = 1'b1;
                e.ldPc = 1'b1;
            end
            checkOutput({tag, "_fetch"}, e, k == fd);
        end
    endtask

    task automatic runDecode(input string tag, input logic [1:0] op);
        outv_t e;
        e = base(3'd2);
        e.ldRa = 1'b1;
        e.ldRdir = 1'b1;
        e.regbRsel = (op == 2'b11) ? 2'd0 : 2'd1;
        checkOutput({tag, "_decode"}, e, 1'($urandom_range(0, 1)));
    endtask

    // Expected cycle sequence of one instruction, built from its class and the ack delays.
    task automatic runInstr(input vec_t v, input string tag);
        outv_t e;
        applyStimulus(v.op, v.cond, v.fn, v.z, v.n);
        runFetch(tag, v.fd);
        runDecode(tag, v.op);
        case (v.expExec)
            3'd3: begin
                e = base(3'd3);
                e.operar = 1'b1;
                e.aluOp = v.fn;
                e.ldRegb = 1'b1;
                e.ldFlags = 1'b1;
                checkOutput({tag, "_alu"}, e, 1'($urandom_range(0, 1)));
            end
            3'd4: for (int k = 0; k <= v.ed; k++) begin
                e = base(3'd4);
                e.memReq = 1'b1;
                e.mux1Pc = 1'b1;
                if (k == v.ed) begin
                    e.ldRegb = 1'b1;
                    e.regbSrc = 1'b1;
                    e.ldFlags = 1'b1;
                end
                checkOutput({tag, "_memrd"}, e, k == v.ed);
            end
            3'd5: for (int k = 0; k <= v.ed; k++) begin
                e = base(3'd5);
                e.memReq = 1'b1;
                e.memWe = 1'b1;
                e.mux1Pc = 1'b1;
                e.regbRsel = 2'd2;
                checkOutput({tag, "_memwr"}, e, k == v.ed);
            end
            default: begin
                e = base(3'd6);
                e.ldPc = v.expTaken;
                e.pcSrc = v.expTaken;
                checkOutput({tag, "_branch"}, e, 1'($urandom_range(0, 1)));
            end
        endcase
    endtask

    vec_t vecs[13];

    initial begin
        outv_t e;
        vec_t v;

        vecs[0]  = '{2'b11, 3'd0, 2'b10, 1'b0, 1'b0, 0, 0, 3'd3, 1'b0};
        vecs[1]  = '{2'b00, 3'd5, 2'b00, 1'b0, 1'b0, 0, 2, 3'd4, 1'b0};
        vecs[2]  = '{2'b01, 3'd2, 2'b01, 1'b0, 1'b0, 0, 1, 3'd5, 1'b0};
        vecs[3]  = '{2'b10, 3'd1, 2'b00, 1'b0, 1'b0, 0, 0, 3'd6, 1'b0};
        vecs[4]  = '{2'b10, 3'd1, 2'b00, 1'b1, 1'b0, 0, 0, 3'd6, 1'b1};
        vecs[5]  = '{2'b10, 3'd0, 2'b00, 1'b0, 1'b0, 0, 0, 3'd6, 1'b1};
        vecs[6]  = '{2'b10, 3'd2, 2'b00, 1'b0, 1'b1, 0, 0, 3'd6, 1'b1};
        vecs[7]  = '{2'b10, 3'd3, 2'b00, 1'b0, 1'b0, 0, 0, 3'd6, 1'b0};
        vecs[8]  = '{2'b10, 3'd4, 2'b00, 1'b0, 1'b1, 0, 0, 3'd6, 1'b1};
        vecs[9]  = '{2'b10, 3'd5, 2'b00, 1'b1, 1'b1, 0, 0, 3'd6, 1'b0};
        vecs[10] = '{2'b10, 3'd6, 2'b00, 1'b0, 1'b0, 0, 0, 3'd6, 1'b1};
        vecs[11] = '{2'b10, 3'd6, 2'b00, 1'b1, 1'b0, 0, 0, 3'd6, 1'b0};
        vecs[12] = '{2'b11, 3'd7, 2'b01, 1'b0, 1'b0, 2, 0, 3'd3, 1'b0};

        @(posedge clk);
        #1;
        doReset("initRst");

        for (int i = 0; i < 13; i++)
            runInstr(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.cond = (v.op == 2'b10) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
            v.fn = 2'($urandom_range(0, 3));
            v.z = 1'($urandom_range(0, 1));
            v.n = 1'($urandom_range(0, 1));
            v.fd = $urandom_range(0, ACK_TO - 1);
            v.ed = $urandom_range(0, ACK_TO - 1);
            v.expExec = execOf(v.op);
            v.expTaken = branchTaken(v.cond, v.z, v.n);
            runInstr(v, $sformatf("rnd%0d", i));
        end

        // Halt instruction: stays halted regardless of ack until reset.
        applyStimulus(2'b10, 3'b111, 2'b00, 1'b1, 1'b1);
        runFetch("halt", 0);
        runDecode("halt", 2'b10);
        for (int k = 0; k < 20; k++) begin
            e = base(3'd7);
            e.halted = 1'b1;
            checkOutput("halt_hold", e, 1'($urandom_range(0, 1)));
        end
        doReset("haltRst");

        // Store whose ack never arrives: four write-request cycles, then error halt.
        applyStimulus(2'b01, 3'd0, 2'b00, 1'b0, 1'b0);
        runFetch("toWr", 0);
        runDecode("toWr", 2'b01);
        for (int k = 0; k < ACK_TO; k++) begin
            e = base(3'd5);
            e.memReq = 1'b1;
            e.memWe = 1'b1;
            e.mux1Pc = 1'b1;
            e.regbRsel = 2'd2;
            checkOutput("toWr_wait", e, 1'b0);
        end
        mErr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = base(3'd7);
            e.halted = 1'b1;
            checkOutput("toWr_halt", e, 1'($urandom_range(0, 1)));
        end
        doReset("toWrRst");

        // Fetch whose ack never arrives.
        for (int k = 0; k < ACK_TO; k++) begin
            e = base(3'd1);
            e.memReq = 1'b1;
            checkOutput("toFetch_wait", e, 1'b0);
        end
        mErr = 1'b1;
        e = base(3'd7);
        e.halted = 1'b1;
        checkOutput("toFetch_halt", e, 1'b1);
        doReset("toFetchRst");

        // Reset in the middle of an outstanding load drops the request at once.
        applyStimulus(2'b00, 3'd0, 2'b00, 1'b0, 1'b0);
        runFetch("midRst", 0);
        runDecode("midRst", 2'b00);
        e = base(3'd4);
        e.memReq = 1'b1;
        e.mux1Pc = 1'b1;
        checkOutput("midRst_memrd", e, 1'b0);
        doReset("midRst");

        v = '{2'b11, 3'd0, 2'b11, 1'b0, 1'b0, 0, 0, 3'd3, 1'b0};
        runInstr(v, "afterRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mr_control_unit.md
Name: mr_control_unit

Overview:
- Multicycle control FSM for the Maquina Rudimentaria datapath.
- Drives the IR, RDIR, PC, REGB, RA and flag load enables, plus the PC/address muxes, ALU operation select and a memory request/acknowledge handshake.
- Decodes the class and condition fields of the instruction held in IR.
- Sits between the datapath and the instruction/data memory; the top-level cpu instantiates it in place of testbench-driven control signals.

Parameters:
- ACK_TIMEOUT, 0, max cycles to wait for mem_ack per access; 0 disables the timeout.
- TW, 8, width of the wait-cycle counter; must hold ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir_op  in  2  IR[15:14] class: 00 LOAD, 01 STORE, 10 BRANCH, 11 ALU.
- ir_cond  in  3  IR[13:11] branch condition.
- ir_fn  in  2  IR[1:0] ALU function, passed through to alu_op.
- flag_z  in  1  registered zero flag.
- flag_n  in  1  registered negative flag.
- mem_ack  in  1  memory access complete this cycle.
- ld_ir, ld_rdir, ld_pc, ld_regb, ld_ra, ld_flags  out  1 each  register load enables.
- reset_pc_sel  out  1  PC input = 8'd0.
- pc_src  out  1  PC input: 0 = PC+1, 1 = RDIR (branch target).
- mux_1_pc  out  1  memory address: 0 = PC, 1 = RDIR.
- regb_src  out  1  REGB write data: 0 = ALU, 1 = memory.
- regb_rsel  out  2  REGB read address: 0 = IR[10:8], 1 = IR[7:5] (index), 2 = IR[13:11] (store data).
- operar  out  1  ALU computes (1) or passes in_a (0).
- alu_op  out  2  ALU function.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- halted  out  1  FSM is in HALT.
- err  out  1  sticky flag: memory timeout occurred.
- state  out  3  current state, for debug.

Behaviour:
- Outputs are Moore, decoded from state. The exceptions are ld_* and next-state updates in the wait states, which also qualify on mem_ack.
- Every output not listed for a state is 0.
- State encodings: RST=0, FETCH=1, DECODE=2, ALU=3, MEM_RD=4, MEM_WR=5, BRANCH=6, HALT=7.
- While rst_n=0:
  - state=RST and err=0, wait counter cleared.
  - Outputs are ld_pc=1, reset_pc_sel=1; all else 0.
- RST: ld_pc=1, reset_pc_sel=1, so PC becomes 0 at the edge. Next state FETCH.
- FETCH: mem_req=1, mux_1_pc=0.
  - On mem_ack: ld_ir=1, ld_pc=1 (pc_src=0), next DECODE.
  - Otherwise hold.
- DECODE: ld_ra=1, ld_rdir=1, regb_rsel=0 for ALU and 1 for LOAD/STORE/BRANCH.
  - Next state by ir_op: 00 MEM_RD, 01 MEM_WR, 10 BRANCH, 11 ALU.
  - Exception: ir_op=10 with ir_cond=111 goes to HALT.
- ALU: operar=1, alu_op=ir_fn, ld_regb=1, regb_src=0, ld_flags=1. Next FETCH.
- MEM_RD: mem_req=1, mux_1_pc=1.
  - On mem_ack: ld_regb=1, regb_src=1, ld_flags=1, operar=0, next FETCH.
- MEM_WR: mem_req=1, mem_we=1, mux_1_pc=1, regb_rsel=2.
  - On mem_ack: next FETCH.
- BRANCH: taken is decoded from ir_cond:
  - 000 always; 001 z; 010 n; 011 z|n; 100 !z; 101 !n; 110 !z&!n.
  - If taken: ld_pc=1, pc_src=1. Next FETCH in either case.
- HALT: halted=1, all loads 0. Only reset exits HALT.
- Latency with zero-wait memory (mem_ack high during the request cycle): every instruction takes 3 cycles. Each mem_ack wait cycle adds 1.
- mem_req stays high until acknowledged; mem_ack is ignored when mem_req=0.
- Timeout (ACK_TIMEOUT>0):
  - The counter increments on each mem_req cycle without mem_ack and clears on ack or when leaving the state.
  - On reaching ACK_TIMEOUT: err=1, next HALT.
- Reset asserted mid-access drops mem_req immediately (asynchronous); no partial register loads.
- PC wrap from 255 to 0 is the datapath's responsibility; the FSM takes no action.

Optional Feature:
- Macro: MR_CU_STEP_EN, which adds an input port step (1 bit).
- With the macro:
  - Add state WAIT_STEP (encoding 7 shared as 3-bit is invalid, so state widens to 4 bits; WAIT_STEP=8).
  - RST and every instruction completion go to WAIT_STEP instead of FETCH.
  - WAIT_STEP drives all outputs 0 and moves to FETCH in the cycle after step=1.
- Without the macro: no step port, state is 3 bits, and transitions go directly to FETCH.

Test Plan:
- Reset then release, mem_ack tied 1 -> reset_pc_sel=1 and ld_pc=1 in RST; FETCH on the next cycle with mem_req=1 and mux_1_pc=0.
- ALU instruction (ir_op=11, ir_fn=10), zero-wait memory -> states 1,2,3 on consecutive cycles; in ALU, operar=1, alu_op=10, ld_regb=1, ld_flags=1.
- LOAD with mem_ack delayed 2 cycles in MEM_RD -> mem_req high for 3 cycles with mux_1_pc=1; ld_regb=1 with regb_src=1 only in the ack cycle.
- BRANCH ir_cond=001 with flag_z=0, then with flag_z=1 -> ld_pc=0 in the first case; ld_pc=1 and pc_src=1 in the second.
- BRANCH ir_cond=111 -> HALT with halted=1; remains there 20 cycles; rst_n pulse returns to RST.
- ACK_TIMEOUT=4, STORE with mem_ack never asserted -> mem_we=1 for 4 cycles, then err=1 and state=HALT.
